riscv_decode_key_stage: RTL and testbench
=========================================

Name: riscv_decode_key_stage

Overview:
- IF→ID pipeline buffer that sits directly upstream of the core's key-lookup control muxes.
- Accepts fetched (pc, inst) pairs over a valid/ready handshake and stores up to two entries (main + skid).
- Presents the head entry together with the pre-extracted lookup key and register fields. The key drives the decoder's key/data mux tables without a combinational path from fetch.

Parameters:
- XLEN, 32, width of pc and inst.
- KEY_LEN, 9, lookup key width; key = {inst[30], inst[14:12], inst[6:2]}. Fixed encoding; other values unsupported.
- RESET_PC, 32'h8000_0000, value driven on out_pc while empty after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all buffered entries (branch/trap redirect).
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_pc  input  XLEN  pc of offered instruction.
- in_inst  input  XLEN  offered instruction word.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decoder consumes head.
- out_pc  output  XLEN  head pc.
- out_inst  output  XLEN  head instruction.
- out_key  output  KEY_LEN  lookup key of head.
- out_rd  output  5  inst[11:7] of head.
- out_rs1  output  5  inst[19:15] of head.
- out_rs2  output  5  inst[24:20] of head.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: EMPTY.
  - out_valid=0, in_ready=1.
  - out_pc=RESET_PC.
  - out_inst=32'h0000_0013 (NOP).
  - out_key, out_rd, out_rs1 and out_rs2 are taken from that NOP.
  - skid contents = 0.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may be held high indefinitely. The offered data must stay stable until in_fire.
- States:
  - EMPTY (0 entries).
  - ONE (main valid).
  - TWO (main + skid valid).
- State transitions:
  - EMPTY + in_fire → ONE; input written to main.
  - ONE + in_fire & !out_fire → TWO; input written to skid.
  - ONE + out_fire & !in_fire → EMPTY.
  - ONE + in_fire & out_fire → ONE; main ← input.
  - TWO + out_fire → ONE; main ← skid. in_ready is 0 in TWO, so no input is taken.
  - All other combinations hold state.
- Latency and throughput:
  - Minimum latency 1 cycle: in_fire at edge N gives out_valid=1 after edge N.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
- Output registering:
  - out_key and the register fields are registered alongside main. No combinational in→out path.
  - in_ready depends only on state; no combinational path from out_ready.
- Flush:
  - Synchronous, priority over all other events: next state EMPTY.
  - An in_fire in the same cycle is dropped.
  - out_valid remains as registered during the flush cycle; the decoder must ignore it.
  - Data registers hold their last value.
- Empty behaviour: when EMPTY, out_* data hold the last main contents and must be ignored by consumers.
- Reset mid-operation: rst asserted at any time forces EMPTY immediately (asynchronously). No entry survives.

Optional Feature:
- Macro: RISCV_DECODE_KEY_STAGE_STALL_CNT_EN.
- With the macro:
  - Extra output stall_cnt (32 bits, reset 0).
  - Increments every cycle with out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Not cleared by flush.
- Without the macro: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_decode_pkg holds:
  - KEY_LEN.
  - Key field bit positions.
  - NOP encoding 32'h0000_0013.
  - Opcode[6:2] constants (OP=5'b01100, OP_IMM=5'b00100, LOAD=5'b00000, STORE=5'b01000, BRANCH=5'b11000, JAL=5'b11011).
  - Stage state encoding.
- One natural sub-module, riscv_inst_key_extract: purely combinational inst → {key, rd, rs1, rs2}. Instantiated once, on the write path to main.

Test Plan:
- Reset then single transfer: rst pulse; in_inst=32'h0020_81B3 (add x3,x1,x2), in_pc=32'h8000_0000, out_ready=1 → next cycle out_valid=1, out_key=9'b0_000_01100, rd=3, rs1=1, rs2=2.
- Back-pressure fill: out_ready=0, three consecutive in_valid offers (sub, addi, lw) → first two accepted, in_ready=0 from the cycle after the second accept, third held. Release out_ready → order sub, addi, lw; sub key=9'b1_000_01100.
- Streaming: 100 back-to-back entries with out_ready=1 → 100 outputs in 100 consecutive cycles after 1-cycle latency, in_ready never 0.
- Flush in TWO with simultaneous in_valid → next cycle out_valid=0, in_ready=1. The offered entry is not output; the next accepted entry appears normally.
- Async reset mid-stream: assert rst between edges while in TWO → out_valid=0 and in_ready=1 immediately, out_pc=32'h8000_0000.
- With RISCV_DECODE_KEY_STAGE_STALL_CNT_EN: hold out_ready=0 for 7 cycles with out_valid=1 → stall_cnt=7. A flush leaves it at 7.

Source files
------------

// File: rtl/riscv_decode_key_stage_pkg.sv
// riscv_decode_pkg: shared key layout, NOP, opcode and stage-state definitions for the decode key stage
package riscv_decode_pkg;
  localparam int KEY_LEN = 9;
  localparam int KEY_F7_BIT = 30;
  localparam int KEY_F3_LO = 12;
  localparam int KEY_OP_LO = 2;
  localparam int RD_LO = 7;
  localparam int RS1_LO = 15;
  localparam int RS2_LO = 20;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [KEY_LEN-1:0] NOP_KEY = {NOP_INST[KEY_F7_BIT], NOP_INST[KEY_F3_LO+:3], NOP_INST[KEY_OP_LO+:5]};
  localparam logic [4:0] OPC_OP = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL = 5'b11011;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE = 2'd1,
    ST_TWO = 2'd2
  } stage_state_e;
endpackage

// File: rtl/riscv_decode_key_stage_if.sv
// riscv_decode_key_stage_if: fetch-side and decoder-side handshake bundle of the decode key stage
interface riscv_decode_key_stage_if #(parameter int XLEN = 32);
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic [riscv_decode_pkg::KEY_LEN-1:0] out_key;
  logic [4:0] out_rd;
  logic [4:0] out_rs1;
  logic [4:0] out_rs2;
  modport slave (
    input in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_key, out_rd, out_rs1, out_rs2
  );
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input in_ready, out_valid, out_pc, out_inst, out_key, out_rd, out_rs1, out_rs2
  );
endinterface

// File: rtl/riscv_decode_key_stage_key_extract.sv
// riscv_inst_key_extract: combinational instruction -> {lookup key, rd, rs1, rs2}
module riscv_inst_key_extract
  import riscv_decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [KEY_LEN-1:0] key,
  output logic [4:0] rd,
  output logic [4:0] rs1,
  output logic [4:0] rs2
);
  logic unused_bits;
  assign key = {inst[KEY_F7_BIT], inst[KEY_F3_LO+:3], inst[KEY_OP_LO+:5]};
  assign rd = inst[RD_LO+:5];
  assign rs1 = inst[RS1_LO+:5];
  assign rs2 = inst[RS2_LO+:5];
  assign unused_bits = ^{inst[31], inst[29:25], inst[1:0]};
endmodule

// File: rtl/riscv_decode_key_stage.sv
// riscv_decode_key_stage: two-entry IF->ID buffer presenting registered pc/inst/key/reg fields
// Optional RISCV_DECODE_KEY_STAGE_STALL_CNT_EN adds a saturating stall_cnt output.
module riscv_decode_key_stage
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic clk,
  input logic rst,
  input logic flush,
  riscv_decode_key_stage_if.slave bus
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  stage_state_e state, state_n;
  logic in_fire, out_fire, load_main, load_skid;
  logic [XLEN-1:0] skid_pc, skid_inst, src_pc, src_inst;
  logic [KEY_LEN-1:0] src_key;
  logic [4:0] src_rd, src_rs1, src_rs2;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  always_comb begin
    load_main = !flush & ((state == ST_EMPTY) ? in_fire : (state == ST_ONE) ? (in_fire & out_fire) : out_fire);
    load_skid = !flush & (state == ST_ONE) & in_fire & !out_fire;
    state_n = flush ? ST_EMPTY :
              (state == ST_EMPTY) ? (in_fire ? ST_ONE : ST_EMPTY) :
              (state == ST_ONE) ? (load_skid ? ST_TWO : (out_fire & !in_fire) ? ST_EMPTY : ST_ONE) :
              (out_fire ? ST_ONE : ST_TWO);
  end
  // main refills from skid when draining TWO, otherwise straight from fetch
  assign src_pc = (state == ST_TWO) ? skid_pc : bus.in_pc;
  assign src_inst = (state == ST_TWO) ? skid_inst : bus.in_inst;
  riscv_inst_key_extract u_key (
    .inst(src_inst[31:0]),
    .key(src_key),
    .rd(src_rd),
    .rs1(src_rs1),
    .rs2(src_rs2)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      bus.out_valid <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.out_pc <= RESET_PC;
      bus.out_inst <= XLEN'(NOP_INST);
      bus.out_key <= NOP_KEY;
      bus.out_rd <= NOP_INST[RD_LO+:5];
      bus.out_rs1 <= NOP_INST[RS1_LO+:5];
      bus.out_rs2 <= NOP_INST[RS2_LO+:5];
      skid_pc <= '0;
      skid_inst <= '0;
    end else begin
      state <= state_n;
      bus.out_valid <= state_n != ST_EMPTY;
      bus.in_ready <= state_n != ST_TWO;
      if (load_main) begin
        bus.out_pc <= src_pc;
        bus.out_inst <= src_inst;
        bus.out_key <= src_key;
        bus.out_rd <= src_rd;
        bus.out_rs1 <= src_rs1;
        bus.out_rs2 <= src_rs2;
      end
      if (load_skid) begin
        skid_pc <= bus.in_pc;
        skid_inst <= bus.in_inst;
      end
    end
  end
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (bus.out_valid & !bus.out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_riscv_decode_key_stage.sv
// tb_riscv_decode_key_stage: directed + random checks of the decode key stage against a queue model
module tb_riscv_decode_key_stage;
  import riscv_decode_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  bit acc;
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_stall = '0;
  riscv_decode_key_stage_if #(.XLEN(32)) bus ();
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  riscv_decode_key_stage #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_state();
    logic [31:0] h;
    chk("out_valid", 32'(bus.out_valid), 32'(q_pc.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q_pc.size() < 2));
    if (q_pc.size() > 0) begin
      h = q_inst[0];
      chk("out_pc", bus.out_pc, q_pc[0]);
      chk("out_inst", bus.out_inst, h);
      chk("out_key", 32'(bus.out_key), 32'({h[30], h[14:12], h[6:2]}));
      chk("out_rd", 32'(bus.out_rd), 32'(h[11:7]));
      chk("out_rs1", 32'(bus.out_rs1), 32'(h[19:15]));
      chk("out_rs2", 32'(bus.out_rs2), 32'(h[24:20]));
    end
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask
  task automatic cycle();
    bit outf;
    @(posedge clk);
    acc = bus.in_valid && q_pc.size() < 2;
    outf = bus.out_ready && q_pc.size() > 0;
    if (q_pc.size() > 0 && !bus.out_ready && m_stall != '1) m_stall++;
    if (flush) begin
      q_pc.delete();
      q_inst.delete();
    end else begin
      if (outf) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (acc) begin
        q_pc.push_back(bus.in_pc);
        q_inst.push_back(bus.in_inst);
      end
    end
    #1 check_state();
  endtask
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_inst = inst;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_pc = '0;
    bus.in_inst = '0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'h8000_0000);
    chk("rst_out_inst", bus.out_inst, 32'h0000_0013);
    chk("rst_out_key", 32'(bus.out_key), 32'(9'b0_000_00100));
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_rs1", 32'(bus.out_rs1), 32'd0);
    chk("rst_out_rs2", 32'(bus.out_rs2), 32'd0);
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    offer(32'h8000_0000, 32'h0020_81B3);
    bus.out_ready = 1'b1;
    cycle();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_key", 32'(bus.out_key), 32'(9'b0_000_01100));
    chk("add_opc", 32'(bus.out_key[4:0]), 32'(OPC_OP));
    chk("add_rd", 32'(bus.out_rd), 32'd3);
    chk("add_rs1", 32'(bus.out_rs1), 32'd1);
    chk("add_rs2", 32'(bus.out_rs2), 32'd2);
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    offer(32'h8000_0004, 32'h4073_02B3);
    cycle();
    chk("fill_ready1", 32'(bus.in_ready), 32'd1);
    offer(32'h8000_0008, 32'h0050_0093);
    cycle();
    chk("fill_ready2", 32'(bus.in_ready), 32'd0);
    offer(32'h8000_000C, 32'h0000_A103);
    cycle();
    cycle();
    chk("lw_held", 32'(bus.in_ready), 32'd0);
    chk("sub_head", bus.out_inst, 32'h4073_02B3);
    chk("sub_key", 32'(bus.out_key), 32'(9'b1_000_01100));
    bus.out_ready = 1'b1;
    cycle();
    chk("addi_head", bus.out_inst, 32'h0050_0093);
    chk("addi_opc", 32'(bus.out_key[4:0]), 32'(OPC_OP_IMM));
    cycle();
    chk("lw_head", bus.out_inst, 32'h0000_A103);
    chk("lw_opc", 32'(bus.out_key[4:0]), 32'(OPC_LOAD));
    bus.in_valid = 1'b0;
    cycle();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      offer(32'h1000_0000 + 32'(i * 4), $urandom);
      cycle();
      if (bus.out_valid) cnt++;
    end
    bus.in_valid = 1'b0;
    cycle();
    if (bus.out_valid) cnt++;
    chk("stream_count", 32'(cnt), 32'd100);
    bus.out_ready = 1'b0;
    offer(32'h2000_0000, $urandom);
    cycle();
    offer(32'h2000_0004, $urandom);
    cycle();
    flush = 1'b1;
    offer(32'hDEAD_0000, $urandom);
    cycle();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    offer(32'h2000_0100, 32'h0000_0063);
    bus.out_ready = 1'b1;
    cycle();
    chk("post_flush_pc", bus.out_pc, 32'h2000_0100);
    chk("post_flush_opc", 32'(bus.out_key[4:0]), 32'(OPC_BRANCH));
    bus.in_valid = 1'b0;
    cycle();
    bus.out_ready = 1'b0;
    offer(32'h3000_0000, $urandom);
    cycle();
    offer(32'h3000_0004, $urandom);
    cycle();
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_pc", bus.out_pc, 32'h8000_0000);
    q_pc.delete();
    q_inst.delete();
    m_stall = '0;
    #2 rst = 1'b0;
    offer(32'h4000_0000, 32'h0040_006F);
    cycle();
    chk("jal_opc", 32'(bus.out_key[4:0]), 32'(OPC_JAL));
    bus.in_valid = 1'b0;
    repeat (7) cycle();
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
    chk("stall_7", stall_cnt, 32'd7);
`endif
    flush = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    flush = 1'b0;
`ifdef RISCV_DECODE_KEY_STAGE_STALL_CNT_EN
    chk("stall_after_flush", stall_cnt, 32'd7);
`endif
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.in_pc = $urandom;
        bus.in_inst = $urandom;
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
